time_comparator: RTL and testbench



---
 rtl/stopwatch_pkg.sv | 9 +
 rtl/mag_compare.sv | 19 +
 rtl/time_comparator.sv | 61 ++++++
 tb/tb_time_comparator.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch datapath types and constants.
package stopwatch_pkg;

  localparam int unsigned TIME_W   = 19;
  localparam int unsigned TIME_MAX = 524287;

  typedef logic [TIME_W-1:0] time_t;

endpackage

// File: rtl/mag_compare.sv
// Combinational unsigned magnitude compare of two WIDTH-bit operands.
module mag_compare #(
  parameter int unsigned WIDTH = 19
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  // Operands are plain unsigned vectors, so relational operators compare magnitude.
  always_comb begin
    eq = (a == b);
    lt = (a < b);
    gt = (a > b);
  end

endmodule

// File: rtl/time_comparator.sv
// Registered time comparator: eq/lt/gt flags one cycle after an enabled sample,
// plus a single-cycle pulse when equality is first reached.
module time_comparator
  import stopwatch_pkg::*;
#(
  parameter int unsigned WIDTH = TIME_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out,
  output logic             lt,
  output logic             gt,
  output logic             match_pulse
);

  logic w_eq;
  logic w_lt;
  logic w_gt;

  logic r_eq;
  logic r_lt;
  logic r_gt;
  logic r_pulse;

  mag_compare #(
    .WIDTH (WIDTH)
  ) u_mag_compare (
    .a  (a),
    .b  (b),
    .eq (w_eq),
    .lt (w_lt),
    .gt (w_gt)
  );

  // Flag and pulse registers; reset wins over enable, pulse self-clears when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_eq    <= 1'b0;
      r_lt    <= 1'b0;
      r_gt    <= 1'b0;
      r_pulse <= 1'b0;
    end else if (en) begin
      r_eq    <= w_eq;
      r_lt    <= w_lt;
      r_gt    <= w_gt;
      // Rising edge of the equality flag, using its pre-edge value.
      r_pulse <= w_eq & ~r_eq;
    end else begin
      r_pulse <= 1'b0;
    end
  end

  assign out         = r_eq;
  assign lt          = r_lt;
  assign gt          = r_gt;
  assign match_pulse = r_pulse;

endmodule

// File: tb/tb_time_comparator.sv
// Directed and randomised checks for time_comparator.
module tb_time_comparator;
  import stopwatch_pkg::*;

  logic  clk;
  logic  rst_n;
  logic  en;
  time_t a;
  time_t b;
  logic  out;
  logic  lt;
  logic  gt;
  logic  match_pulse;

  int n_checks;
  int n_fail;

  localparam time_t MaxV = time_t'(TIME_MAX);

  time_comparator #(
    .WIDTH (TIME_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .a           (a),
    .b           (b),
    .out         (out),
    .lt          (lt),
    .gt          (gt),
    .match_pulse (match_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    rst_n = 1'b0; en = 1'b1; a = 19'd5; b = 19'd5;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp = 4'b0000;
      n_checks++;
      if ({out, lt, gt, match_pulse} !== exp) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %b expected %b", i, {out, lt, gt, match_pulse}, exp);
      end
    end
    rst_n = 1'b1;
    tick();
    exp = 4'b1001;
    n_checks++;
    if ({out, lt, gt, match_pulse} !== exp) begin
      n_fail++;
      $display("FAIL reset_release: got %b expected %b", {out, lt, gt, match_pulse}, exp);
    end
  endtask

  task automatic test_equal_hold();
    logic [3:0] exp;
    a = 19'd1; b = 19'd2; en = 1'b1;
    tick();
    exp = 4'b0100;
    n_checks++;
    if ({out, lt, gt, match_pulse} !== exp) begin
      n_fail++;
      $display("FAIL eqhold_pre: got %b expected %b", {out, lt, gt, match_pulse}, exp);
    end
    a = 19'd12345; b = 19'd12345;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp = (i == 0) ? 4'b1001 : 4'b1000;
      n_checks++;
      if ({out, lt, gt, match_pulse} !== exp) begin
        n_fail++;
        $display("FAIL eqhold[%0d]: got %b expected %b", i, {out, lt, gt, match_pulse}, exp);
      end
    end
  endtask

  task automatic test_extremes();
    time_t      va [3];
    time_t      vb [3];
    logic [3:0] ve [3];
    va[0] = '0;   vb[0] = MaxV; ve[0] = 4'b0100;
    va[1] = MaxV; vb[1] = '0;   ve[1] = 4'b0010;
    va[2] = MaxV; vb[2] = MaxV; ve[2] = 4'b1001;
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = va[i]; b = vb[i];
      tick();
      n_checks++;
      if ({out, lt, gt, match_pulse} !== ve[i]) begin
        n_fail++;
        $display("FAIL extreme[%0d]: got %b expected %b", i, {out, lt, gt, match_pulse}, ve[i]);
      end
    end
    // Zero-equals-zero boundary after a non-equal sample.
    a = '0; b = 19'd3;
    tick();
    a = '0; b = '0;
    tick();
    n_checks++;
    if ({out, lt, gt, match_pulse} !== 4'b1001) begin
      n_fail++;
      $display("FAIL extreme_zero: got %b expected %b", {out, lt, gt, match_pulse}, 4'b1001);
    end
  endtask

  task automatic test_enable_hold();
    en = 1'b1; a = 19'd100; b = 19'd200;
    tick();
    n_checks++;
    if ({out, lt, gt, match_pulse} !== 4'b0100) begin
      n_fail++;
      $display("FAIL enhold_lt: got %b expected %b", {out, lt, gt, match_pulse}, 4'b0100);
    end
    en = 1'b0; a = 19'd7; b = 19'd7;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({out, lt, gt, match_pulse} !== 4'b0100) begin
        n_fail++;
        $display("FAIL enhold[%0d]: got %b expected %b", i, {out, lt, gt, match_pulse}, 4'b0100);
      end
    end
    en = 1'b1;
    tick();
    n_checks++;
    if ({out, lt, gt, match_pulse} !== 4'b1001) begin
      n_fail++;
      $display("FAIL enhold_reen: got %b expected %b", {out, lt, gt, match_pulse}, 4'b1001);
    end
  endtask

  task automatic test_random();
    logic       m_out;
    logic [3:0] exp;
    m_out = out_model_seed();
    en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      a = time_t'($urandom_range(TIME_MAX, 0));
      if ($urandom_range(1, 0) == 1) b = a;
      else b = time_t'($urandom_range(TIME_MAX, 0));
      exp = {(a == b), (a < b), (a > b), ((a == b) && !m_out)};
      m_out = (a == b);
      tick();
      n_checks++;
      if ({out, lt, gt, match_pulse} !== exp) begin
        n_fail++;
        $display("FAIL random[%0d] a=%0d b=%0d: got %b expected %b", i, a, b,
                 {out, lt, gt, match_pulse}, exp);
      end
      n_checks++;
      if ($countones({out, lt, gt}) != 1) begin
        n_fail++;
        $display("FAIL onehot[%0d]: got %b expected exactly one flag", i, {out, lt, gt});
      end
    end
  endtask

  // The previous test left a=b=7 sampled with en=1, so the equality flag is set.
  function automatic logic out_model_seed();
    return 1'b1;
  endfunction

  task automatic test_rearm();
    logic [3:0] ve [5];
    ve[0] = 4'b1001; ve[1] = 4'b1000; ve[2] = 4'b0000; ve[3] = 4'b1001; ve[4] = 4'b1000;
    en = 1'b1; a = 19'd0; b = 19'd1;
    tick();
    a = 19'd42; b = 19'd42;
    for (int i = 0; i < 5; i++) begin
      rst_n = (i == 2) ? 1'b0 : 1'b1;
      tick();
      n_checks++;
      if ({out, lt, gt, match_pulse} !== ve[i]) begin
        n_fail++;
        $display("FAIL rearm[%0d]: got %b expected %b", i, {out, lt, gt, match_pulse}, ve[i]);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    a        = '0;
    b        = '0;
    #2;
    test_reset();
    test_equal_hold();
    test_extremes();
    test_enable_hold();
    test_random();
    test_rearm();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
